// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch/decode front end.
//   - fetch_state_t : fetch/decode control states
//   - OP_HALT_DEFAULT : opcode that parks the front end until a redirect
//   - field bit positions of the 16-bit instruction word
//   - instr_t : packed view of the instruction register
package fetch_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_WAIT   = 3'd2,
      ST_HOLD   = 3'd3,
      ST_HALTED = 3'd4
   } fetch_state_t;

   localparam logic [3:0] OP_HALT_DEFAULT = 4'hF;

   // Instruction word layout: opcode | rd | rs | rt/imm
   // rt and imm5 overlap: rt = IR[5:3], imm5 = IR[4:0].
   localparam int OPC_MSB = 15;
   localparam int OPC_LSB = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 9;
   localparam int RS_MSB  = 8;
   localparam int RS_LSB  = 6;
   localparam int RT_MSB  = 5;
   localparam int RT_LSB  = 3;
   localparam int IMM_MSB = 4;
   localparam int IMM_LSB = 0;

   typedef struct packed {
      logic [OPC_MSB-OPC_LSB:0] opcode;
      logic [RD_MSB-RD_LSB:0]   rd;
      logic [RS_MSB-RS_LSB:0]   rs;
      logic [RT_MSB-IMM_LSB:0]  rt_imm;
   } instr_t;

endpackage

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: program counter, single-outstanding instruction fetch,
// instruction register and decoded-field handshake to the execute stage.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   imem_req/imem_addr      read request (REQ state only), word address = PC
//   imem_ready              memory accepts the request this cycle
//   imem_rvalid/imem_rdata  read return (only honoured in WAIT)
//   dec_valid/dec_ready     decoded instruction handshake
//   dec_opcode..dec_imm5    fields of the instruction register
//   dec_pc                  fetch address of the presented instruction
//   redirect_valid/_pc      branch/jump: replaces PC this cycle
//   halted                  parked after consuming an OP_HALT instruction
import fetch_pkg::*;

module instr_fetch_decode #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [3:0]  OP_HALT  = OP_HALT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [15:0] imem_rdata,
   output logic        dec_valid,
   input  logic        dec_ready,
   output logic [3:0]  dec_opcode,
   output logic [2:0]  dec_rd,
   output logic [2:0]  dec_rs,
   output logic [2:0]  dec_rt,
   output logic [4:0]  dec_imm5,
   output logic [15:0] dec_pc,
   input  logic        redirect_valid,
   input  logic [15:0] redirect_pc,
   output logic        halted
);

   fetch_state_t state_reg, state_next;
   logic         drop_reg, drop_next;
   logic [15:0]  pc_reg;
   logic [15:0]  fetch_pc_reg;
   logic [15:0]  ir_reg;
   logic [15:0]  dec_pc_reg;

   instr_t       ir_fields;
   logic         accept;
   logic         handshake;
   logic         capture;

   assign ir_fields = instr_t'(ir_reg);
   assign accept    = (state_reg == ST_REQ) && imem_ready;
   assign handshake = (state_reg == ST_HOLD) && dec_ready;
   // A redirect in the same cycle as the return also kills the data.
   assign capture   = (state_reg == ST_WAIT) && imem_rvalid &&
                      !drop_reg && !redirect_valid;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         drop_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         drop_reg  <= drop_next;
      end
   end

   // Next-state logic; redirect has priority in every state
   always_comb begin
      state_next = state_reg;
      drop_next  = drop_reg;
      case (state_reg)
         ST_IDLE: begin
            state_next = ST_REQ;
         end
         ST_REQ: begin
            if (accept) begin
               state_next = ST_WAIT;
               // The read just issued targets the pre-redirect PC.
               drop_next  = redirect_valid;
            end
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               drop_next = 1'b0;
               if (drop_reg || redirect_valid) begin
                  state_next = ST_REQ;
               end else begin
                  state_next = ST_HOLD;
               end
            end else if (redirect_valid) begin
               drop_next = 1'b1;
            end
         end
         ST_HOLD: begin
            if (redirect_valid) begin
               state_next = ST_REQ;
            end else if (handshake) begin
               state_next = (ir_fields.opcode == OP_HALT) ? ST_HALTED : ST_REQ;
            end
         end
         ST_HALTED: begin
            if (redirect_valid) begin
               state_next = ST_REQ;
            end
         end
         default: begin
            state_next = ST_IDLE;
            drop_next  = 1'b0;
         end
      endcase
   end

   // Outputs decoded from the state register only
   always_comb begin
      imem_req  = 1'b0;
      dec_valid = 1'b0;
      halted    = 1'b0;
      case (state_reg)
         ST_REQ:    imem_req  = 1'b1;
         ST_HOLD:   dec_valid = 1'b1;
         ST_HALTED: halted    = 1'b1;
         default: ;
      endcase
   end

   // PC, fetch address and instruction register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_reg       <= RESET_PC;
         fetch_pc_reg <= 16'h0000;
         ir_reg       <= 16'h0000;
         dec_pc_reg   <= 16'h0000;
      end else begin
         if (redirect_valid) begin
            pc_reg <= redirect_pc;
         end else if (accept) begin
            pc_reg <= pc_reg + 16'd1;
         end
         if (accept) begin
            fetch_pc_reg <= pc_reg;
         end
         if (capture) begin
            ir_reg     <= imem_rdata;
            dec_pc_reg <= fetch_pc_reg;
         end
      end
   end

   assign imem_addr  = pc_reg;
   assign dec_opcode = ir_fields.opcode;
   assign dec_rd     = ir_fields.rd;
   assign dec_rs     = ir_fields.rs;
   assign dec_rt     = ir_fields.rt_imm[RT_MSB-IMM_LSB:RT_LSB-IMM_LSB];
   assign dec_imm5   = ir_fields.rt_imm[IMM_MSB-IMM_LSB:0];
   assign dec_pc     = dec_pc_reg;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Testbench for instr_fetch_decode: directed vector table, hand-written
// corner sequences (stall, redirect in WAIT, halt, PC wrap, reset in WAIT)
// and a randomized run against a transaction-level reference model.
module tb_instr_fetch_decode;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [15:0] imem_rdata = 16'h0000;
   logic        dec_valid;
   logic        dec_ready = 1'b0;
   logic [3:0]  dec_opcode;
   logic [2:0]  dec_rd;
   logic [2:0]  dec_rs;
   logic [2:0]  dec_rt;
   logic [4:0]  dec_imm5;
   logic [15:0] dec_pc;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic        halted;

   int checks = 0;
   int errors = 0;

   instr_fetch_decode #(.RESET_PC(16'h0010), .OP_HALT(4'hF)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_opcode(dec_opcode), .dec_rd(dec_rd), .dec_rs(dec_rs),
      .dec_rt(dec_rt), .dec_imm5(dec_imm5), .dec_pc(dec_pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halted(halted)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   typedef struct {
      logic [15:0] word;
      logic [3:0]  opc;
      logic [2:0]  rd;
      logic [2:0]  rs;
      logic [2:0]  rt;
      logic [4:0]  imm;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req();
      int n = 0;
      while (!imem_req && n < 20) begin
         tick();
         n++;
      end
      chk("req_seen", imem_req, 1);
   endtask

   function automatic logic [63:0] cur_sig();
      return {30'd0, dec_pc, dec_opcode, dec_rd, dec_rs, dec_rt, dec_imm5};
   endfunction

   // Single fetch: accept, return data next cycle, stall in HOLD, consume.
   task automatic do_fetch(input vec_t v, input logic [15:0] addr, input int stall, input bit exp_halt);
      logic [15:0] nxt;
      nxt = addr + 16'd1;
      wait_req();
      chk("req_addr", imem_addr, addr);
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      chk("wait_no_req", imem_req, 0);
      chk("wait_no_valid", dec_valid, 0);
      imem_rvalid = 1'b1;
      imem_rdata  = v.word;
      tick();
      imem_rvalid = 1'b0;
      for (int c = 0; c <= stall; c++) begin
         chk("dec_valid", dec_valid, 1);
         chk("dec_opcode", dec_opcode, v.opc);
         chk("dec_rd", dec_rd, v.rd);
         chk("dec_rs", dec_rs, v.rs);
         chk("dec_rt", dec_rt, v.rt);
         chk("dec_imm5", dec_imm5, v.imm);
         chk("dec_pc", dec_pc, addr);
         chk("hold_no_req", imem_req, 0);
         if (c < stall) tick();
      end
      dec_ready = 1'b1;
      tick();
      dec_ready = 1'b0;
      chk("dec_valid_fall", dec_valid, 0);
      if (exp_halt) begin
         chk("halted", halted, 1);
         chk("halt_no_req", imem_req, 0);
      end else begin
         chk("next_req", imem_req, 1);
         chk("next_addr", imem_addr, nxt);
      end
      $display("fetch addr=%04h word=%04h stall=%0d halt=%0d", addr, v.word, stall, exp_halt);
   endtask

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      logic [15:0] w;
      w = a * 16'h6F3B + 16'h1D29;
      if (w[15:12] == 4'hF) w[15:12] = 4'hE;
      return w;
   endfunction

   initial begin
      vec_t vstall, vhalt, vwrap;
      logic [15:0] q[$];
      logic [15:0] exp_addr;
      logic [15:0] a;
      logic [15:0] w;
      logic [63:0] prev_sig;
      bit prev_stall;
      bit mem_pend;
      int mem_delay;
      logic [15:0] mem_data;
      bit accept;
      bit hs;
      int hs_count;

      vecs[0] = '{16'h1A45, 4'h1, 3'd5, 3'd1, 3'd0, 5'h05};
      vecs[1] = '{16'h7FFF, 4'h7, 3'd7, 3'd7, 3'd7, 5'h1F};
      vecs[2] = '{16'h0000, 4'h0, 3'd0, 3'd0, 3'd0, 5'h00};
      vecs[3] = '{16'hE3C7, 4'hE, 3'd1, 3'd7, 3'd0, 5'h07};
      vecs[4] = '{16'h5B6D, 4'h5, 3'd5, 3'd5, 3'd5, 5'h0D};
      vstall  = '{16'h2468, 4'h2, 3'd2, 3'd1, 3'd5, 5'h08};
      vhalt   = '{16'hF000, 4'hF, 3'd0, 3'd0, 3'd0, 5'h00};
      vwrap   = vecs[4];

      // Reset state
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_req", imem_req, 0);
      chk("rst_addr", imem_addr, 16'h0010);
      chk("rst_valid", dec_valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_fields", cur_sig(), 64'd0);
      rst_n = 1'b1;

      // Vector table, back-to-back fetches from RESET_PC
      for (int i = 0; i < 5; i++) begin
         do_fetch(vecs[i], 16'h0010 + 16'(i), 0, 1'b0);
      end

      // Execute stalls 5 cycles in HOLD
      do_fetch(vstall, 16'h0015, 5, 1'b0);

      // Redirect during WAIT: returned data must be dropped
      wait_req();
      chk("redir_req_addr", imem_addr, 16'h0016);
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0200;
      tick();
      redirect_valid = 1'b0;
      chk("redir_wait_no_req", imem_req, 0);
      imem_rvalid = 1'b1;
      imem_rdata  = 16'hBEEF;
      tick();
      imem_rvalid = 1'b0;
      chk("drop_no_valid", dec_valid, 0);
      chk("drop_req", imem_req, 1);
      chk("drop_addr", imem_addr, 16'h0200);
      $display("redirect in WAIT to 0200, BEEF dropped");

      // Halt, spurious returns while halted, then redirect out
      do_fetch(vhalt, 16'h0200, 0, 1'b1);
      for (int c = 0; c < 10; c++) begin
         imem_rvalid = (c % 3 == 0);
         imem_rdata  = 16'h1234;
         tick();
         chk("halt_stay", {halted, imem_req, dec_valid}, 3'b100);
      end
      imem_rvalid    = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0004;
      tick();
      redirect_valid = 1'b0;
      chk("unhalt", halted, 0);
      chk("unhalt_req", imem_req, 1);
      chk("unhalt_addr", imem_addr, 16'h0004);
      $display("halt released by redirect to 0004");

      // Redirect in REQ without acceptance, then PC wrap at FFFF
      redirect_valid = 1'b1;
      redirect_pc    = 16'hFFFF;
      tick();
      redirect_valid = 1'b0;
      chk("req_redir_addr", imem_addr, 16'hFFFF);
      do_fetch(vwrap, 16'hFFFF, 0, 1'b0);

      // Reset asserted in WAIT; later rvalid must be ignored
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("arst_req", imem_req, 0);
      chk("arst_addr", imem_addr, 16'h0010);
      chk("arst_fields", cur_sig(), 64'd0);
      chk("arst_valid", dec_valid, 0);
      tick();
      rst_n = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 16'h1A45;
      tick();
      imem_rvalid = 1'b0;
      chk("post_rst_valid", dec_valid, 0);
      chk("post_rst_req", imem_req, 1);
      chk("post_rst_addr", imem_addr, 16'h0010);
      chk("post_rst_fields", cur_sig(), 64'd0);
      $display("reset in WAIT, fetch restarts at 0010");

      // Randomized run against the transaction-level model
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_addr   = 16'h0010;
      prev_stall = 1'b0;
      prev_sig   = '0;
      mem_pend   = 1'b0;
      mem_delay  = 0;
      mem_data   = '0;
      hs_count   = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if (prev_stall) begin
            chk("stall_valid", dec_valid, 1);
            chk("stall_fields", cur_sig(), prev_sig);
         end
         if (dec_valid) chk("valid_live", q.size() != 0, 1);

         imem_rvalid = 1'b0;
         imem_rdata  = 16'($urandom);
         if (mem_pend) begin
            if (mem_delay == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_data;
               mem_pend    = 1'b0;
            end else begin
               mem_delay--;
            end
         end else if ($urandom_range(0, 7) == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 16'hF000;
         end
         imem_ready     = ($urandom_range(0, 2) != 0);
         dec_ready      = ($urandom_range(0, 1) == 1);
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc    = 16'($urandom);

         accept = imem_req && imem_ready;
         hs     = dec_valid && dec_ready;
         if (accept) begin
            chk("rand_addr", imem_addr, exp_addr);
            mem_pend  = 1'b1;
            mem_delay = $urandom_range(0, 2);
            mem_data  = mem_word(imem_addr);
         end
         if (hs && q.size() != 0) begin
            a = q.pop_front();
            w = mem_word(a);
            chk("rand_pc", dec_pc, a);
            chk("rand_fields", {dec_opcode, dec_rd, dec_rs, dec_rt, dec_imm5},
                {w[15:12], w[11:9], w[8:6], w[5:3], w[4:0]});
            hs_count++;
            $display("rand consume pc=%04h word=%04h", a, w);
         end
         if (redirect_valid) begin
            q.delete();
            exp_addr = redirect_pc;
         end else if (accept) begin
            q.push_back(imem_addr);
            exp_addr = imem_addr + 16'd1;
         end
         prev_stall = dec_valid && !dec_ready && !redirect_valid;
         prev_sig   = cur_sig();
         tick();
      end
      imem_rvalid    = 1'b0;
      redirect_valid = 1'b0;
      chk("rand_progress", hs_count >= 50, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
